// File: rtl/inst_queue.sv
// Instruction queue between fetch and decode: a circular buffer of {pc, inst}
// entries with fetch back-pressure, flush-to-new-PC and a sticky overflow flag.
module inst_queue #(
    parameter int DEPTH       = 16,
    parameter int AFULL_SLACK = 2
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        rdy_in,
    input  logic        inst_rdy_if_in,
    input  logic [31:0] inst_if_in,
    output logic        iqfull_if_out,
    input  logic        flush_in,
    input  logic [31:0] flush_pc_in,
    output logic        inst_valid_out,
    output logic [31:0] inst_out,
    output logic [31:0] inst_pc_out,
    input  logic        inst_ready_in,
    output logic        overflow_out
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } entry_t;

    entry_t        mem_q [DEPTH];

    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [AW:0]   count_q, count_d;
    logic [31:0]   push_pc_q, push_pc_d;
    logic          overflow_q, overflow_d;

    logic          full;
    logic          push_req;
    logic          push;
    logic          pop;

    assign full           = (count_q == FULL_COUNT);
    assign inst_valid_out = (count_q != '0);
    // Early warning so fetches already in flight still find a free slot.
    assign iqfull_if_out  = ((32'(count_q) + 32'(AFULL_SLACK)) >= 32'(DEPTH));
    assign overflow_out   = overflow_q;

    assign push_req = rdy_in && inst_rdy_if_in && !flush_in;
    assign push     = push_req && !full;
    assign pop      = rdy_in && inst_valid_out && inst_ready_in && !flush_in;

    // No bypass: the head is always read from storage, so a push into an
    // empty queue becomes visible one cycle later.
    assign inst_out    = mem_q[head_q].inst;
    assign inst_pc_out = mem_q[head_q].pc;

    always_comb begin
        // NOTE: every next-state signal gets its hold value first, so no path
        // through this block can leave one unassigned and infer a latch.
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        push_pc_d  = push_pc_q;
        overflow_d = overflow_q;

        if (rdy_in) begin
            if (flush_in) begin
                head_d    = '0;
                tail_d    = '0;
                count_d   = '0;
                push_pc_d = flush_pc_in;
            end else begin
                if (push) begin
                    tail_d    = tail_q + 1'b1;
                    push_pc_d = push_pc_q + 32'd4;
                end
                if (pop) begin
                    head_d = head_q + 1'b1;
                end
                unique case ({push, pop})
                    2'b10:   count_d = count_q + 1'b1;
                    2'b01:   count_d = count_q - 1'b1;
                    default: count_d = count_q;
                endcase
                if (push_req && full) begin
                    overflow_d = 1'b1;
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of block ordering.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            push_pc_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            push_pc_q  <= push_pc_d;
            overflow_q <= overflow_d;
        end
    end

    // NOTE: entry storage has no reset; validity is carried entirely by
    // count_q, so clearing the array would only cost reset fan-out.
    always_ff @(posedge clk_in) begin
        if (push) begin
            mem_q[tail_q] <= '{pc: push_pc_q, inst: inst_if_in};
        end
    end

endmodule

// File: tb/tb_inst_queue.sv
// Directed bench for inst_queue: ordering, back-pressure, overflow, wrap,
// flush, global stall and asynchronous reset, with hand-computed expectations.
module tb_inst_queue;

    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic        rdy_in;
    logic        inst_rdy_if_in;
    logic [31:0] inst_if_in;
    logic        iqfull_if_out;
    logic        flush_in;
    logic [31:0] flush_pc_in;
    logic        inst_valid_out;
    logic [31:0] inst_out;
    logic [31:0] inst_pc_out;
    logic        inst_ready_in;
    logic        overflow_out;

    int n_cmp = 0;
    int n_err = 0;

    inst_queue #(.DEPTH(16), .AFULL_SLACK(2)) dut (
        .clk_in         (clk_in),
        .rst_n_in       (rst_n_in),
        .rdy_in         (rdy_in),
        .inst_rdy_if_in (inst_rdy_if_in),
        .inst_if_in     (inst_if_in),
        .iqfull_if_out  (iqfull_if_out),
        .flush_in       (flush_in),
        .flush_pc_in    (flush_pc_in),
        .inst_valid_out (inst_valid_out),
        .inst_out       (inst_out),
        .inst_pc_out    (inst_pc_out),
        .inst_ready_in  (inst_ready_in),
        .overflow_out   (overflow_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic push_word(input logic [31:0] w);
        inst_rdy_if_in = 1'b1;
        inst_if_in     = w;
        step();
        inst_rdy_if_in = 1'b0;
    endtask

    task automatic pop_one();
        inst_ready_in = 1'b1;
        step();
        inst_ready_in = 1'b0;
    endtask

    initial begin
        rst_n_in       = 1'b1;
        rdy_in         = 1'b1;
        inst_rdy_if_in = 1'b0;
        inst_if_in     = '0;
        flush_in       = 1'b0;
        flush_pc_in    = '0;
        inst_ready_in  = 1'b0;

        // Reset state
        #1 rst_n_in = 1'b0;
        #1;
        check("rst_valid", 32'(inst_valid_out), 32'd0);
        check("rst_iqfull", 32'(iqfull_if_out), 32'd0);
        check("rst_overflow", 32'(overflow_out), 32'd0);
        #10 rst_n_in = 1'b1;

        // Three pushes without popping
        push_word(32'hA);
        check("push_latency_valid", 32'(inst_valid_out), 32'd1);
        push_word(32'hB);
        push_word(32'hC);
        check("head_inst_A", inst_out, 32'hA);
        check("head_pc_A", inst_pc_out, 32'd0);
        check("iqfull_at_3", 32'(iqfull_if_out), 32'd0);
        pop_one();
        check("head_inst_B", inst_out, 32'hB);
        check("head_pc_B", inst_pc_out, 32'd4);
        pop_one();
        check("head_inst_C", inst_out, 32'hC);
        check("head_pc_C", inst_pc_out, 32'd8);
        pop_one();
        check("empty_after_3_pops", 32'(inst_valid_out), 32'd0);

        // Fill to full, then overflow (next pc is 12)
        for (int i = 0; i < 14; i++) begin
            push_word(32'h100 + 32'(i));
            if (i == 12) check("iqfull_at_13", 32'(iqfull_if_out), 32'd0);
        end
        check("iqfull_at_14", 32'(iqfull_if_out), 32'd1);
        push_word(32'h10E);
        push_word(32'h10F);
        check("no_overflow_at_16", 32'(overflow_out), 32'd0);
        push_word(32'hDEAD);
        check("overflow_set", 32'(overflow_out), 32'd1);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("full_inst_%0d", i), inst_out, 32'h100 + 32'(i));
            check($sformatf("full_pc_%0d", i), inst_pc_out, 32'd12 + 32'(4 * i));
            pop_one();
        end
        check("empty_after_16_pops", 32'(inst_valid_out), 32'd0);
        check("overflow_sticky", 32'(overflow_out), 32'd1);

        // Steady state: five entries, push+pop for 40 cycles (next pc is 76)
        for (int i = 0; i < 5; i++) push_word(32'h200 + 32'(i));
        for (int k = 0; k < 40; k++) begin
            check($sformatf("steady_inst_%0d", k), inst_out, 32'h200 + 32'(k));
            check($sformatf("steady_pc_%0d", k), inst_pc_out, 32'd76 + 32'(4 * k));
            inst_rdy_if_in = 1'b1;
            inst_if_in     = 32'h205 + 32'(k);
            inst_ready_in  = 1'b1;
            step();
        end
        inst_rdy_if_in = 1'b0;
        inst_ready_in  = 1'b0;
        for (int k = 40; k < 45; k++) begin
            check($sformatf("drain_inst_%0d", k), inst_out, 32'h200 + 32'(k));
            check($sformatf("drain_pc_%0d", k), inst_pc_out, 32'd76 + 32'(4 * k));
            pop_one();
        end
        check("empty_after_steady", 32'(inst_valid_out), 32'd0);

        // Flush with a push and pop attempted in the same cycle
        for (int i = 0; i < 6; i++) push_word(32'h300 + 32'(i));
        check("valid_before_flush", 32'(inst_valid_out), 32'd1);
        inst_rdy_if_in = 1'b1;
        inst_if_in     = 32'hBAD;
        inst_ready_in  = 1'b1;
        flush_in       = 1'b1;
        flush_pc_in    = 32'h1000;
        step();
        flush_in       = 1'b0;
        inst_rdy_if_in = 1'b0;
        inst_ready_in  = 1'b0;
        check("flush_valid", 32'(inst_valid_out), 32'd0);
        check("flush_iqfull", 32'(iqfull_if_out), 32'd0);
        push_word(32'h400);
        check("post_flush_valid", 32'(inst_valid_out), 32'd1);
        check("post_flush_pc", inst_pc_out, 32'h1000);
        check("post_flush_inst", inst_out, 32'h400);
        push_word(32'h401);

        // Global stall with push and pop requested
        rdy_in         = 1'b0;
        inst_rdy_if_in = 1'b1;
        inst_if_in     = 32'h555;
        inst_ready_in  = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            check($sformatf("stall_inst_%0d", k), inst_out, 32'h400);
            check($sformatf("stall_pc_%0d", k), inst_pc_out, 32'h1000);
            check($sformatf("stall_valid_%0d", k), 32'(inst_valid_out), 32'd1);
        end
        rdy_in         = 1'b1;
        inst_rdy_if_in = 1'b0;
        inst_ready_in  = 1'b0;
        pop_one();
        check("after_stall_inst", inst_out, 32'h401);
        check("after_stall_pc", inst_pc_out, 32'h1004);
        pop_one();
        check("after_stall_empty", 32'(inst_valid_out), 32'd0);

        // Asynchronous reset between edges with nine entries queued
        for (int i = 0; i < 9; i++) push_word(32'h600 + 32'(i));
        check("valid_before_reset", 32'(inst_valid_out), 32'd1);
        #3 rst_n_in = 1'b0;
        #1;
        check("async_rst_valid", 32'(inst_valid_out), 32'd0);
        check("async_rst_iqfull", 32'(iqfull_if_out), 32'd0);
        check("async_rst_overflow", 32'(overflow_out), 32'd0);
        #2 rst_n_in = 1'b1;
        push_word(32'h700);
        check("post_reset_valid", 32'(inst_valid_out), 32'd1);
        check("post_reset_pc", inst_pc_out, 32'd0);
        check("post_reset_inst", inst_out, 32'h700);
        pop_one();
        check("post_reset_empty", 32'(inst_valid_out), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/inst_queue.md
INST_QUEUE -- requirements
Module: inst_queue

Interface
REQ-001 Parameter DEPTH, default 16, number of entries; power of two, at least 4.
REQ-002 Parameter AFULL_SLACK, default 2, free entries still remaining when iqfull_if_out asserts; covers fetches already in flight.
REQ-003 clk_in  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n_in  input  1  asynchronous, active-low reset.
REQ-005 rdy_in  input  1  global enable; low freezes all state.
REQ-006 inst_rdy_if_in  input  1  push strobe from fetch; one instruction per cycle while high.
REQ-007 inst_if_in  input  32  instruction word pushed when inst_rdy_if_in is high.
REQ-008 iqfull_if_out  output  1  back-pressure to fetch.
REQ-009 flush_in  input  1  discards all queue contents, e.g. on branch mispredict.
REQ-010 flush_pc_in  input  32  PC of the first instruction pushed after a flush.
REQ-011 inst_valid_out  output  1  head entry is available.
REQ-012 inst_out  output  32  head instruction word.
REQ-013 inst_pc_out  output  32  PC of the head instruction.
REQ-014 inst_ready_in  input  1  consumer accepts the head entry this cycle.
REQ-015 overflow_out  output  1  sticky flag: a push was dropped.

Function
REQ-016 Storage is a circular buffer of DEPTH entries, each {pc[31:0], inst[31:0]}, addressed by head and tail pointers of log2(DEPTH) bits that wrap modulo DEPTH.
REQ-017 count (log2(DEPTH)+1 bits) tracks occupancy 0..DEPTH; empty is count==0, full is count==DEPTH.
REQ-018 A push occurs when rdy_in && inst_rdy_if_in && !flush_in && count<DEPTH: write {push_pc, inst_if_in} at tail, then tail+1 and push_pc+4.
REQ-019 push_pc resets to 0; on flush it loads flush_pc_in.
REQ-020 A pop occurs when rdy_in && inst_valid_out && inst_ready_in && !flush_in: head+1.
REQ-021 A simultaneous push and pop leaves count unchanged, and both pointers advance.
REQ-022 A push and pop on an entry-count of 0 do not bypass; a pushed entry becomes visible on the next cycle, so minimum latency from push to inst_valid_out is 1 cycle.
REQ-023 inst_valid_out = (count!=0), combinational from registered state; inst_out and inst_pc_out show the head entry and hold stable while valid && !ready.
REQ-024 iqfull_if_out = (count + AFULL_SLACK >= DEPTH), combinational from registered count; it does not depend on inst_rdy_if_in.
REQ-025 A push attempted when count==DEPTH is dropped, and overflow_out sets and holds until reset.
REQ-026 flush_in (with rdy_in) takes priority over push and pop: the next state has head=tail=0, count=0, and push_pc=flush_pc_in.
REQ-027 rdy_in low: no push, pop, flush, or pointer change; outputs reflect held state.
REQ-028 Entry contents are not reset; only pointers, count, push_pc and overflow_out are reset.

Reset
REQ-029 While rst_n_in is low, state is cleared immediately without a clock: head=tail=count=0, push_pc=0, overflow_out=0, so inst_valid_out=0 and iqfull_if_out=0.
REQ-030 Reset asserted mid-operation discards all entries; the first push after release carries pc 0.
REQ-031 Reset deassertion is synchronised externally; the block takes no action on the release edge itself.

Verification
REQ-032 Reset, push 3 words 0xA,0xB,0xC on consecutive cycles with ready=0 -> count=3; head shows inst 0xA with pc 0; iqfull_if_out=0.
REQ-033 DEPTH=16: push 14 words without popping -> iqfull_if_out rises the cycle after the 14th push; 2 more pushes accepted; a 17th push sets overflow_out=1 and count stays 16.
REQ-034 Steady state with count=5 and push+pop every cycle for 40 cycles -> count stays 5, pointers wrap cleanly, popped pcs increment by 4 in order.
REQ-035 count=6, then flush_in with flush_pc_in=0x1000 while a push is attempted -> the push is dropped, and the next cycle has count=0 and inst_valid_out=0; the next push carries pc 0x1000.
REQ-036 rdy_in=0 for 5 cycles with push and ready both high -> count, head, and outputs unchanged.
REQ-037 Assert rst_n_in low between clock edges with count=9 -> inst_valid_out drops immediately without a clock edge; after release, pushed pc starts at 0.
